// File: rtl/hc193_count_sequencer_if.sv
// Request/acknowledge bundle between the requesters and the 74HC193 count sequencer.
interface hc193_count_sequencer_if;
  logic       clrReq;
  logic       ldReq;
  logic [3:0] ldData;
  logic       upReq;
  logic       dnReq;
  logic       clrAck;
  logic       ldAck;
  logic       upAck;
  logic       dnAck;
  logic       busy;

  modport master (
    output clrReq, ldReq, ldData, upReq, dnReq,
    input  clrAck, ldAck, upAck, dnAck, busy
  );

  modport slave (
    input  clrReq, ldReq, ldData, upReq, dnReq,
    output clrAck, ldAck, upAck, dnAck, busy
  );
endinterface

// File: rtl/hc193_count_sequencer.sv
// Sequencer that turns clear/load/up/down requests into 74HC193 pin sequences
// and keeps a shadow copy of the counter value and its terminal-count flags.
module hc193_count_sequencer #(
  parameter int unsigned PULSE_CYC = 1
) (
  input  logic                          clk_i,
  input  logic                          rst_ni,
  hc193_count_sequencer_if.slave        bus,
  output logic                          cpu_o,
  output logic                          cpd_o,
  output logic                          mr_o,
  output logic                          plBar_o,
  output logic [3:0]                    d_o,
  output logic [3:0]                    qShadow_o,
  output logic                          tcuBar_o,
  output logic                          tcdBar_o
);

  typedef enum logic [2:0] {IDLE, CLR, LOAD, LOW, HIGH} state_e;

  localparam logic [4:0] ActiveEnd = 5'(PULSE_CYC);
  localparam logic [4:0] AckSlot   = 5'(PULSE_CYC + 1);

  state_e     state_q, state_d;
  logic [4:0] cyc_q, cyc_d;
  logic       dnDir_q, dnDir_d;
  logic       ptrDn_q, ptrDn_d;
  logic [3:0] count_q, count_d;
  logic [3:0] data_q, data_d;
  logic       cpu_q, cpu_d, cpd_q, cpd_d, mr_q, mr_d, plBar_q, plBar_d;
  logic       tcuBar_q, tcuBar_d, tcdBar_q, tcdBar_d;
  logic       clrAck_q, clrAck_d, ldAck_q, ldAck_d;
  logic       upAck_q, upAck_d, dnAck_q, dnAck_d;
  logic       busy_q, busy_d;

  // CLR and LOAD stay in their state one extra cycle to present the ACK,
  // so every operation keeps its request pin away from the IDLE sampler.
  always_comb begin
    state_d = state_q;
    cyc_d   = cyc_q;
    dnDir_d = dnDir_q;
    ptrDn_d = ptrDn_q;
    count_d = count_q;
    data_d  = data_q;

    unique case (state_q)
      IDLE: begin
        cyc_d = 5'd1;
        if (bus.clrReq) begin
          state_d = CLR;
        end else if (bus.ldReq) begin
          state_d = LOAD;
          data_d  = bus.ldData;
        end else if (bus.upReq || bus.dnReq) begin
          state_d = LOW;
          dnDir_d = bus.dnReq && (!bus.upReq || ptrDn_q);
          ptrDn_d = !dnDir_d;
        end
      end
      CLR, LOAD: begin
        if (cyc_q == AckSlot) begin
          state_d = IDLE;
        end else begin
          cyc_d = cyc_q + 5'd1;
          if (cyc_d == AckSlot) begin
            count_d = (state_q == CLR) ? 4'd0 : data_q;
          end
        end
      end
      LOW: begin
        if (cyc_q == ActiveEnd) begin
          state_d = HIGH;
          count_d = dnDir_q ? (count_q - 4'd1) : (count_q + 4'd1);
        end else begin
          cyc_d = cyc_q + 5'd1;
        end
      end
      HIGH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase

    busy_d   = (state_d != IDLE);
    mr_d     = (state_d == CLR) && (cyc_d <= ActiveEnd);
    plBar_d  = !((state_d == LOAD) && (cyc_d <= ActiveEnd));
    cpu_d    = !((state_d == LOW) && !dnDir_d);
    cpd_d    = !((state_d == LOW) && dnDir_d);
    clrAck_d = (state_d == CLR) && (cyc_d == AckSlot);
    ldAck_d  = (state_d == LOAD) && (cyc_d == AckSlot);
    upAck_d  = (state_d == HIGH) && !dnDir_d;
    dnAck_d  = (state_d == HIGH) && dnDir_d;
    tcuBar_d = !((count_d == 4'hF) && !cpu_d);
    tcdBar_d = !((count_d == 4'h0) && !cpd_d);
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      cyc_q    <= 5'd0;
      dnDir_q  <= 1'b0;
      ptrDn_q  <= 1'b0;
      count_q  <= 4'd0;
      data_q   <= 4'd0;
      cpu_q    <= 1'b1;
      cpd_q    <= 1'b1;
      mr_q     <= 1'b0;
      plBar_q  <= 1'b1;
      tcuBar_q <= 1'b1;
      tcdBar_q <= 1'b1;
      clrAck_q <= 1'b0;
      ldAck_q  <= 1'b0;
      upAck_q  <= 1'b0;
      dnAck_q  <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cyc_q    <= cyc_d;
      dnDir_q  <= dnDir_d;
      ptrDn_q  <= ptrDn_d;
      count_q  <= count_d;
      data_q   <= data_d;
      cpu_q    <= cpu_d;
      cpd_q    <= cpd_d;
      mr_q     <= mr_d;
      plBar_q  <= plBar_d;
      tcuBar_q <= tcuBar_d;
      tcdBar_q <= tcdBar_d;
      clrAck_q <= clrAck_d;
      ldAck_q  <= ldAck_d;
      upAck_q  <= upAck_d;
      dnAck_q  <= dnAck_d;
      busy_q   <= busy_d;
    end
  end

  assign cpu_o      = cpu_q;
  assign cpd_o      = cpd_q;
  assign mr_o       = mr_q;
  assign plBar_o    = plBar_q;
  assign d_o        = data_q;
  assign qShadow_o  = count_q;
  assign tcuBar_o   = tcuBar_q;
  assign tcdBar_o   = tcdBar_q;
  assign bus.clrAck = clrAck_q;
  assign bus.ldAck  = ldAck_q;
  assign bus.upAck  = upAck_q;
  assign bus.dnAck  = dnAck_q;
  assign bus.busy   = busy_q;

endmodule

// File: tb/tb_hc193_count_sequencer.sv
// Randomized scoreboard bench: a request-level model predicts the served operation
// order and resulting counter value; a monitor checks each ACK and pin pulse shape.
module tb_hc193_count_sequencer;
  localparam int P = 2;
  localparam int OP_CLR = 0;
  localparam int OP_LD  = 1;
  localparam int OP_UP  = 2;
  localparam int OP_DN  = 3;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       cpu, cpd, mr, plBar, tcuBar, tcdBar;
  logic [3:0] d, qShadow;

  hc193_count_sequencer_if bus();

  hc193_count_sequencer #(.PULSE_CYC(P)) dut (
    .clk_i     (clk),
    .rst_ni    (rst_n),
    .bus       (bus),
    .cpu_o     (cpu),
    .cpd_o     (cpd),
    .mr_o      (mr),
    .plBar_o   (plBar),
    .d_o       (d),
    .qShadow_o (qShadow),
    .tcuBar_o  (tcuBar),
    .tcdBar_o  (tcdBar)
  );

  always #5 clk = ~clk;

  typedef struct {
    int op;
    int qBefore;
    int qAfter;
    int dAfter;
  } exp_t;

  exp_t expQ[$];
  int   checks = 0;
  int   passes = 0;
  int   modelQ = 0;
  int   modelD = 0;
  bit   modelPreferDn = 1'b0;

  task automatic checkOutput(input string name, input int actual, input int expected);
    checks++;
    if (actual == expected) passes++;
    else $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
  endtask

  function automatic void pushExp(input int op, input int qNew, input int dNew);
    exp_t e;
    e.op = op;
    e.qBefore = modelQ;
    e.qAfter = qNew;
    e.dAfter = dNew;
    expQ.push_back(e);
    modelQ = qNew;
    modelD = dNew;
  endfunction

  // Service order: clear, then load, then counts alternating from the preferred side.
  function automatic void predict(input bit c, input bit l, input bit u, input bit dn, input int data);
    bit upLeft;
    bit dnLeft;
    bit servedDn;
    upLeft = u;
    dnLeft = dn;
    if (c) pushExp(OP_CLR, 0, modelD);
    if (l) pushExp(OP_LD, data, data);
    while (upLeft || dnLeft) begin
      if (upLeft && dnLeft) servedDn = modelPreferDn;
      else servedDn = dnLeft;
      if (servedDn) begin
        pushExp(OP_DN, (modelQ + 15) % 16, modelD);
        dnLeft = 1'b0;
      end else begin
        pushExp(OP_UP, (modelQ + 1) % 16, modelD);
        upLeft = 1'b0;
      end
      modelPreferDn = !servedDn;
    end
  endfunction

  task automatic monitorLoop();
    int   mrLen = 0, plLen = 0, cpuLen = 0, cpdLen = 0, busyLen = 0;
    bit   tcuSeen = 1'b0, tcdSeen = 1'b0;
    logic [3:0] ackBits;
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst_n) begin
        mrLen = 0; plLen = 0; cpuLen = 0; cpdLen = 0; busyLen = 0;
        tcuSeen = 1'b0; tcdSeen = 1'b0;
      end else begin
        checkOutput("exclusivePins", int'(mr) + int'(!plBar) + int'(!cpu) + int'(!cpd), int'(mr || !plBar || !cpu || !cpd));
        if (mr) mrLen++;
        else if (mrLen != 0) begin checkOutput("mrWidth", mrLen, P); mrLen = 0; end
        if (!plBar) plLen++;
        else if (plLen != 0) begin checkOutput("plWidth", plLen, P); plLen = 0; end
        if (!cpu) cpuLen++;
        else if (cpuLen != 0) begin checkOutput("cpuWidth", cpuLen, P); cpuLen = 0; end
        if (!cpd) cpdLen++;
        else if (cpdLen != 0) begin checkOutput("cpdWidth", cpdLen, P); cpdLen = 0; end
        if (bus.busy) busyLen++;
        else busyLen = 0;
        if (!tcuBar) tcuSeen = 1'b1;
        if (!tcdBar) tcdSeen = 1'b1;
        ackBits = {bus.clrAck, bus.ldAck, bus.upAck, bus.dnAck};
        if (ackBits != 4'b0000) begin
          if (expQ.size() == 0) begin
            checkOutput("unexpectedAck", int'(ackBits), 0);
          end else begin
            e = expQ.pop_front();
            checkOutput("ackKind", int'(ackBits), 8 >> e.op);
            checkOutput("qShadow", int'(qShadow), e.qAfter);
            checkOutput("dPins", int'(d), e.dAfter);
            checkOutput("opCycles", busyLen, P + 1);
            checkOutput("tcuLowSeen", int'(tcuSeen), int'(e.op == OP_UP && e.qBefore == 15));
            checkOutput("tcdLowSeen", int'(tcdSeen), int'(e.op == OP_DN && e.qBefore == 0));
          end
          tcuSeen = 1'b0;
          tcdSeen = 1'b0;
        end
      end
    end
  endtask

  task automatic drainRequests();
    int budget = 0;
    while ((bus.clrReq || bus.ldReq || bus.upReq || bus.dnReq) && budget < 100) begin
      @(negedge clk);
      if (bus.clrAck) bus.clrReq = 1'b0;
      if (bus.ldAck)  bus.ldReq  = 1'b0;
      if (bus.upAck)  bus.upReq  = 1'b0;
      if (bus.dnAck)  bus.dnReq  = 1'b0;
      budget++;
    end
    checkOutput("reqsPending", int'({bus.clrReq, bus.ldReq, bus.upReq, bus.dnReq}), 0);
    @(negedge clk);
  endtask

  task automatic applyStimulus(input bit c, input bit l, input bit u, input bit dn, input logic [3:0] data);
    predict(c, l, u, dn, int'(data));
    bus.ldData = data;
    bus.clrReq = c;
    bus.ldReq  = l;
    bus.upReq  = u;
    bus.dnReq  = dn;
    drainRequests();
  endtask

  task automatic resetDut(input bit holdUp);
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    bus.clrReq = 1'b0;
    bus.ldReq  = 1'b0;
    bus.dnReq  = 1'b0;
    bus.upReq  = holdUp;
    bus.ldData = 4'd0;
    #1;
    checkOutput("rstCpu", int'(cpu), 1);
    checkOutput("rstCpd", int'(cpd), 1);
    checkOutput("rstPlBar", int'(plBar), 1);
    checkOutput("rstMr", int'(mr), 0);
    checkOutput("rstD", int'(d), 0);
    checkOutput("rstQ", int'(qShadow), 0);
    checkOutput("rstTc", int'({tcuBar, tcdBar}), 3);
    checkOutput("rstAcks", int'({bus.clrAck, bus.ldAck, bus.upAck, bus.dnAck}), 0);
    checkOutput("rstBusy", int'(bus.busy), 0);
    expQ.delete();
    modelQ = 0;
    modelD = 0;
    modelPreferDn = 1'b0;
    repeat (2) @(negedge clk);
    #2;
    rst_n = 1'b1;
  endtask

  initial begin
    int budget;
    int mask;
    bus.clrReq = 1'b0;
    bus.ldReq  = 1'b0;
    bus.upReq  = 1'b0;
    bus.dnReq  = 1'b0;
    bus.ldData = 4'd0;
    fork
      monitorLoop();
    join_none

    // Up request held through reset is granted on the first edge after release.
    resetDut(1'b1);
    predict(1'b0, 1'b0, 1'b1, 1'b0, 0);
    @(negedge clk);
    checkOutput("grantAfterRelease", int'({bus.busy, cpu}), 2);
    drainRequests();

    applyStimulus(1'b0, 1'b1, 1'b0, 1'b0, 4'hE);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 4'h0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b0, 4'h0);
    applyStimulus(1'b0, 1'b0, 1'b0, 1'b1, 4'h0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 4'h0);
    applyStimulus(1'b0, 1'b0, 1'b1, 1'b1, 4'h0);
    applyStimulus(1'b1, 1'b1, 1'b1, 1'b0, 4'h7);

    // Reset in the middle of an up count aborts it without an ACK.
    bus.upReq = 1'b1;
    budget = 0;
    while (cpu && budget < 20) begin
      @(negedge clk);
      budget++;
    end
    checkOutput("cpuLowBeforeAbort", int'(cpu), 0);
    resetDut(1'b0);
    repeat (2) @(negedge clk);

    for (int i = 0; i < 60; i++) begin
      mask = int'($urandom_range(1, 15));
      applyStimulus(mask[3], mask[2], mask[1], mask[0], 4'($urandom_range(0, 15)));
    end

    repeat (4) @(negedge clk);
    checkOutput("queueDrained", expQ.size(), 0);
    $display("[TB] %0d/%0d checks passed", passes, checks);
    $finish;
  end
endmodule
